// File: rtl/mm_write_sink_fifo.sv
// ============================================================================
// mm_write_sink_fifo : bus write strobes captured into a FIFO, drained as a
//                      valid/ready stream; overflow counted, never stalled.
// Optional feature macro: ADDR_FILTER_EN (accept only BASE..BASE+SPAN-1)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mm_write_sink_fifo #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int BASE  = 0,
  parameter int SPAN  = 256
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [AW-1:0]            address,
  input  logic                     write,
  input  logic [DW-1:0]            writedata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AW-1:0]            out_addr,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [7:0]               drop_cnt
);

  localparam int                 c_PW    = $clog2(DEPTH);
  localparam int                 c_LW    = c_PW + 1;
  localparam logic [c_LW-1:0]    c_FULL  = c_LW'(DEPTH);
  localparam logic [7:0]         c_SAT   = 8'hFF;

  logic [AW-1:0]   r_mem_addr [DEPTH];
  logic [DW-1:0]   r_mem_data [DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_LW-1:0] r_level;
  logic [7:0]      r_drop_cnt;

  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_full;
  logic w_store;
  logic w_drop;

`ifdef ADDR_FILTER_EN
  // Window bounds held one bit wider than the bus so BASE+SPAN cannot wrap.
  localparam logic [AW:0] c_LO = (AW+1)'(BASE);
  localparam logic [AW:0] c_HI = (AW+1)'(BASE + SPAN);

  assign w_accept = ({1'b0, address} >= c_LO) && ({1'b0, address} < c_HI);
`else
  logic w_unused_cfg;

  assign w_unused_cfg = BASE[0] ^ SPAN[0];
  assign w_accept     = 1'b1;
`endif

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == c_FULL);
  assign w_push  = write & w_accept;
  assign w_pop   = !w_empty & out_ready;
  // A pop in the same cycle frees the slot the incoming write needs.
  assign w_store = w_push & (!w_full | w_pop);
  assign w_drop  = w_push & w_full & !w_pop;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_store, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop && (r_drop_cnt != c_SAT)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_store && !reset) begin
      r_mem_addr[r_wr_ptr] <= address;
      r_mem_data[r_wr_ptr] <= writedata;
    end
  end

  // Head is forced to zero while empty so the reset view is all-zero.
  assign out_addr  = w_empty ? '0 : r_mem_addr[r_rd_ptr];
  assign out_data  = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign out_valid = !w_empty;
  assign empty     = w_empty;
  assign full      = w_full;
  assign level     = r_level;
  assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mm_write_sink_fifo.sv
// ============================================================================
// tb_mm_write_sink_fifo : directed scenarios plus random traffic against a
//                         queue-based reference model of the write sink FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mm_write_sink_fifo;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
`ifdef ADDR_FILTER_EN
  localparam int BASE  = 16;
  localparam int SPAN  = 16;
`else
  localparam int BASE  = 0;
  localparam int SPAN  = 256;
`endif

  logic          CLK = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic          write;
  logic [DW-1:0] writedata;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [3:0]    level;
  logic          full;
  logic          empty;
  logic [7:0]    drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_q[$];
  int          m_drops;
  int          m_npop;
  logic [15:0] m_last;

  always #5 CLK = ~CLK;

  mm_write_sink_fifo #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .BASE(BASE), .SPAN(SPAN)
  ) u_dut (
    .CLK       (CLK),
    .reset     (reset),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit accepted(input int a);
`ifdef ADDR_FILTER_EN
    return (a >= BASE) && (a < BASE + SPAN);
`else
    return 1'b1;
`endif
  endfunction

  // Apply one cycle of inputs, advance the model, then compare all outputs.
  task automatic step(input logic r, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic rdy);
    bit pop;
    reset = r; write = w; address = a; writedata = d; out_ready = rdy;
    if (r) begin
      m_q.delete();
      m_drops = 0;
    end else begin
      pop = (m_q.size() != 0) && rdy;
      if (pop) begin
        m_last = m_q.pop_front();
        m_npop++;
      end
      if (w && accepted(int'(a))) begin
        if (m_q.size() < DEPTH) m_q.push_back({a, d});
        else if (m_drops < 255) m_drops++;
      end
    end
    @(posedge CLK);
    #1;
    check("level", 32'(level), 32'(m_q.size()));
    check("valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("empty", 32'(empty), 32'(m_q.size() == 0));
    check("full", 32'(full), 32'(m_q.size() == DEPTH));
    check("drop", 32'(drop_cnt), 32'(m_drops));
    if (m_q.size() != 0) begin
      check("head", {16'h0, out_addr, out_data}, {16'h0, m_q[0]});
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 8'd99, 8'd99, rdy);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'd99, 8'd99, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; address = '0; writedata = '0; out_ready = 1'b0;
    m_drops = 0; m_npop = 0; m_last = '0;

    // reset held 3 cycles
    do_reset(3);
    idle(1'b0);
    check("t1_level", 32'(level), 32'd0);
    check("t1_empty", 32'(empty), 32'd1);

`ifndef ADDR_FILTER_EN
    // write every other cycle, consumer always ready
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'(i), 8'(i), 1'b1);
      check("t2_valid", 32'(out_valid), 32'd1);
      check("t2_data", 32'(out_data), 32'(i));
      idle(1'b1);
      check("t2_lvl_le1", 32'(level <= 4'd1), 32'd1);
    end
    check("t2_popped", 32'(m_npop), 32'd3);

    // overflow: 10 writes into 8 slots
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'(i), 8'(i), 1'b0);
      if (i == 7) check("t3_full8", 32'(full), 32'd1);
    end
    check("t3_drop", 32'(drop_cnt), 32'd2);
    m_npop = 0;
    drain();
    check("t3_npop", 32'(m_npop), 32'd8);
    check("t3_last", 32'(m_last[7:0]), 32'd7);
    check("t3_empty", 32'(empty), 32'd1);

    // full FIFO with simultaneous push and pop
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(i), 8'(i), 1'b0);
    step(1'b0, 1'b1, 8'hAA, 8'hAA, 1'b1);
    check("t4_level", 32'(level), 32'd8);
    check("t4_drop", 32'(drop_cnt), 32'd0);
    drain();
    check("t4_last", 32'(m_last[7:0]), 32'hAA);

    // mid-operation reset with a write in the reset cycle
    do_reset(1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(i + 1), 8'(i + 1), 1'b0);
    step(1'b1, 1'b1, 8'h77, 8'h77, 1'b0);
    check("t5_level", 32'(level), 32'd0);
    check("t5_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b1, 8'h55, 8'h55, 1'b0);
    m_npop = 0;
    drain();
    check("t5_npop", 32'(m_npop), 32'd1);
    check("t5_data", 32'(m_last[7:0]), 32'h55);
`else
    // address window 16..31
    do_reset(1);
    step(1'b0, 1'b1, 8'd15, 8'd15, 1'b0);
    step(1'b0, 1'b1, 8'd16, 8'd16, 1'b0);
    step(1'b0, 1'b1, 8'd31, 8'd31, 1'b0);
    step(1'b0, 1'b1, 8'd32, 8'd32, 1'b0);
    check("t6_level", 32'(level), 32'd2);
    check("t6_drop", 32'(drop_cnt), 32'd0);
    check("t6_head", 32'(out_data), 32'd16);
    m_npop = 0;
    drain();
    check("t6_npop", 32'(m_npop), 32'd2);
    check("t6_last", 32'(m_last[7:0]), 32'd31);
`endif

    // random traffic, occasional reset, idle bus parked at 99
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      logic r, w, rdy;
      logic [7:0] a, d;
      r   = ($urandom_range(0, 299) == 0);
      w   = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 40 : 75));
      a   = w ? 8'($urandom_range(0, 255)) : 8'd99;
      d   = w ? 8'($urandom_range(0, 255)) : 8'd99;
      step(r, w, a, d, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
